// File: rtl/alu_8_bit_checker_if.sv
// Observed ALU transaction bus feeding the checker.
// The stimulus side drives it; the checker only listens.
interface alu_8_bit_checker_if;
  logic       smp_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       CarryOut;

  modport master (
    output smp_valid,
    output A,
    output B,
    output ALU_Sel,
    output ALU_Out,
    output CarryOut
  );

  modport slave (
    input smp_valid,
    input A,
    input B,
    input ALU_Sel,
    input ALU_Out,
    input CarryOut
  );
endinterface

// File: rtl/alu_8_bit_checker.sv
// Two-stage 8-bit ALU result checker with run FSM,
// saturating pass/fail/skip counters and opcode coverage.
module alu_8_bit_checker #(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  alu_8_bit_checker_if.slave    bus,
  output logic                  chk_valid,
  output logic                  chk_pass,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [CNT_W-1:0]      skip_cnt,
  output logic [3:0]            first_fail_sel,
  output logic                  err_sticky,
  output logic [15:0]           op_seen,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       acc;
  logic       s1_valid;
  logic [7:0] s1_a;
  logic [7:0] s1_b;
  logic [3:0] s1_sel;
  logic [7:0] s1_out;
  logic       s1_co;

  logic [7:0] exp_out;
  logic [8:0] sum9;
  logic [15:0] prod;
  logic       exp_co;
  logic       skip;
  logic       match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // a sample arriving with start is dropped along with the flush
  always_comb begin
    acc     = (state_q == RUN) && bus.smp_valid && !start;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (start) begin
          state_d = RUN;
        end else if (op_seen == 16'hFFFF && !s1_valid && !acc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
      s1_out   <= '0;
      s1_co    <= 1'b0;
    end else begin
      s1_valid <= acc;
      if (acc) begin
        s1_a   <= bus.A;
        s1_b   <= bus.B;
        s1_sel <= bus.ALU_Sel;
        s1_out <= bus.ALU_Out;
        s1_co  <= bus.CarryOut;
      end
    end
  end

  always_comb begin
    sum9    = {1'b0, s1_a} + {1'b0, s1_b};
    prod    = s1_a * s1_b;
    exp_co  = sum9[8];
    exp_out = 8'h00;
    unique case (s1_sel)
      4'h0: exp_out = sum9[7:0];
      4'h1: exp_out = s1_a - s1_b;
      4'h2: exp_out = prod[7:0];
      4'h3: exp_out = (s1_b == 8'h00) ? 8'h00 : s1_a / s1_b;
      4'h4: exp_out = {s1_a[6:0], 1'b0};
      4'h5: exp_out = {1'b0, s1_a[7:1]};
      4'h6: exp_out = {s1_a[6:0], s1_a[7]};
      4'h7: exp_out = {s1_a[0], s1_a[7:1]};
      4'h8: exp_out = s1_a & s1_b;
      4'h9: exp_out = s1_a | s1_b;
      4'hA: exp_out = s1_a ^ s1_b;
      4'hB: exp_out = ~(s1_a | s1_b);
      4'hC: exp_out = ~(s1_a & s1_b);
      4'hD: exp_out = ~(s1_a ^ s1_b);
      4'hE: exp_out = {7'd0, s1_a > s1_b};
      4'hF: exp_out = {7'd0, s1_a == s1_b};
      default: exp_out = 8'h00;
    endcase
    skip  = (s1_sel == 4'h3) && (s1_b == 8'h00);
    match = (exp_out == s1_out) && (exp_co == s1_co);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_valid      <= 1'b0;
      chk_pass       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      skip_cnt       <= '0;
      first_fail_sel <= '0;
      err_sticky     <= 1'b0;
      op_seen        <= '0;
    end else if (start) begin
      chk_valid      <= 1'b0;
      chk_pass       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      skip_cnt       <= '0;
      first_fail_sel <= '0;
      err_sticky     <= 1'b0;
      op_seen        <= '0;
    end else begin
      chk_valid <= s1_valid;
      chk_pass  <= s1_valid && (skip || match);
      if (s1_valid) begin
        op_seen[s1_sel] <= 1'b1;
        if (skip) begin
          if (skip_cnt != '1) skip_cnt <= skip_cnt + CNT_W'(1);
        end else if (match) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          if (!err_sticky) begin
            err_sticky     <= 1'b1;
            first_fail_sel <= s1_sel;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_8_bit_checker.sv
// Directed-vector bench for alu_8_bit_checker.
// A second instance with CNT_W=2 watches the same bus for saturation.
module tb_alu_8_bit_checker;

  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  alu_8_bit_checker_if bus ();

  logic       chk_valid, chk_pass, err_sticky, done;
  logic [7:0] pass_cnt, fail_cnt, skip_cnt;
  logic [3:0] first_fail_sel;
  logic [15:0] op_seen;

  logic       chk_valid2, chk_pass2, err_sticky2, done2;
  logic [1:0] pass_cnt2, fail_cnt2, skip_cnt2;
  logic [3:0] first_fail_sel2;
  logic [15:0] op_seen2;

  alu_8_bit_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .chk_valid(chk_valid), .chk_pass(chk_pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
    .first_fail_sel(first_fail_sel), .err_sticky(err_sticky),
    .op_seen(op_seen), .done(done)
  );

  alu_8_bit_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .chk_valid(chk_valid2), .chk_pass(chk_pass2),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .skip_cnt(skip_cnt2),
    .first_fail_sel(first_fail_sel2), .err_sticky(err_sticky2),
    .op_seen(op_seen2), .done(done2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] out;
    logic       co;
    logic       pass;
  } vec_t;

  vec_t tab[24];
  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic vld);
    bus.smp_valid = vld;
    bus.A         = v.a;
    bus.B         = v.b;
    bus.ALU_Sel   = v.sel;
    bus.ALU_Out   = v.out;
    bus.CarryOut  = v.co;
  endtask

  task automatic do_start();
    bus.smp_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_one(input int idx);
    drive(tab[idx], 1'b1);
    step();
    bus.smp_valid = 1'b0;
    chk($sformatf("latency_early[%0d]", idx), chk_valid, 0);
    step();
    chk($sformatf("strobe[%0d]", idx), chk_valid, 1);
    chk($sformatf("pass[%0d]", idx), chk_pass, tab[idx].pass);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, chk_valid, 0);
    chk({tag, "_pass"}, chk_pass, 0);
    chk({tag, "_cnts"}, {pass_cnt, fail_cnt, skip_cnt}, 0);
    chk({tag, "_ffs"}, first_fail_sel, 0);
    chk({tag, "_err"}, err_sticky, 0);
    chk({tag, "_seen"}, op_seen, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    // A=AA B=55 sweep with a correct ALU; AA+55=0FF so carry is 0 throughout
    tab[0]  = '{8'hAA, 8'h55, 4'h0, 8'hFF, 1'b0, 1'b1};
    tab[1]  = '{8'hAA, 8'h55, 4'h1, 8'h55, 1'b0, 1'b1};
    tab[2]  = '{8'hAA, 8'h55, 4'h2, 8'h72, 1'b0, 1'b1};
    tab[3]  = '{8'hAA, 8'h55, 4'h3, 8'h02, 1'b0, 1'b1};
    tab[4]  = '{8'hAA, 8'h55, 4'h4, 8'h54, 1'b0, 1'b1};
    tab[5]  = '{8'hAA, 8'h55, 4'h5, 8'h55, 1'b0, 1'b1};
    tab[6]  = '{8'hAA, 8'h55, 4'h6, 8'h55, 1'b0, 1'b1};
    tab[7]  = '{8'hAA, 8'h55, 4'h7, 8'h55, 1'b0, 1'b1};
    tab[8]  = '{8'hAA, 8'h55, 4'h8, 8'h00, 1'b0, 1'b1};
    tab[9]  = '{8'hAA, 8'h55, 4'h9, 8'hFF, 1'b0, 1'b1};
    tab[10] = '{8'hAA, 8'h55, 4'hA, 8'hFF, 1'b0, 1'b1};
    tab[11] = '{8'hAA, 8'h55, 4'hB, 8'h00, 1'b0, 1'b1};
    tab[12] = '{8'hAA, 8'h55, 4'hC, 8'hFF, 1'b0, 1'b1};
    tab[13] = '{8'hAA, 8'h55, 4'hD, 8'h00, 1'b0, 1'b1};
    tab[14] = '{8'hAA, 8'h55, 4'hE, 8'h01, 1'b0, 1'b1};
    tab[15] = '{8'hAA, 8'h55, 4'hF, 8'h00, 1'b0, 1'b1};
    // single-shot vectors: faults, carry, divide-by-zero, misc passes
    tab[16] = '{8'hAA, 8'h55, 4'h8, 8'hFF, 1'b0, 1'b0};
    tab[17] = '{8'hAA, 8'h55, 4'h9, 8'h00, 1'b0, 1'b0};
    tab[18] = '{8'hFF, 8'h01, 4'h8, 8'h01, 1'b0, 1'b0};
    tab[19] = '{8'hFF, 8'h01, 4'h8, 8'h01, 1'b1, 1'b1};
    tab[20] = '{8'h10, 8'h00, 4'h3, 8'h00, 1'b0, 1'b1};
    tab[21] = '{8'h07, 8'h03, 4'h1, 8'h04, 1'b0, 1'b1};
    tab[22] = '{8'h55, 8'hAA, 4'hE, 8'h00, 1'b0, 1'b1};
    tab[23] = '{8'h80, 8'h00, 4'h4, 8'h00, 1'b0, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    drive(tab[0], 1'b0);
    step();
    step();
    all_zero("reset");
    rst = 1'b0;
    step();

    // back-to-back sweep: strobe k-2 appears at step k
    do_start();
    for (int k = 0; k < 19; k++) begin
      chk($sformatf("sweep_valid[%0d]", k), chk_valid,
          (k >= 2 && k <= 17) ? 1 : 0);
      if (k >= 2 && k <= 17)
        chk($sformatf("sweep_pass[%0d]", k - 2), chk_pass, tab[k - 2].pass);
      if (k >= 16)
        chk($sformatf("sweep_done[%0d]", k), done, (k == 18) ? 1 : 0);
      if (k < 16) drive(tab[k], 1'b1);
      else bus.smp_valid = 1'b0;
      step();
    end
    chk("sweep_pass_cnt", pass_cnt, 16);
    chk("sweep_fail_cnt", fail_cnt, 0);
    chk("sweep_seen", op_seen, 16'hFFFF);
    chk("sweep_sat2", pass_cnt2, 3);
    chk("sweep_done_hold", done, 1);

    // DONE -> RUN clears the run
    do_start();
    chk("restart_done", done, 0);
    chk("restart_cnt", pass_cnt, 0);
    chk("restart_seen", op_seen, 0);
    for (int i = 16; i < 24; i++) begin
      run_one(i);
      if (i == 16) begin
        chk("first_fail_cnt", fail_cnt, 1);
        chk("first_fail_err", err_sticky, 1);
        chk("first_fail_sel", first_fail_sel, 8);
      end
      if (i == 17) chk("second_fail_sel", first_fail_sel, 8);
      if (i == 20) begin
        chk("div0_skip", skip_cnt, 1);
        chk("div0_seen3", op_seen[3], 1);
        chk("div0_pass", pass_cnt, 1);
        chk("div0_fail", fail_cnt, 3);
      end
    end
    chk("mix_pass_cnt", pass_cnt, 4);
    chk("mix_fail_cnt", fail_cnt, 3);
    chk("mix_skip_cnt", skip_cnt, 1);
    chk("mix_seen", op_seen, 16'h431A);
    chk("mix_ffs", first_fail_sel, 8);
    chk("mix_run", done, 0);

    // saturation at CNT_W=2 after five passes
    do_start();
    for (int i = 0; i < 5; i++) run_one(i);
    chk("five_pass_w8", pass_cnt, 5);
    chk("five_pass_w2", pass_cnt2, 3);

    // reset one cycle after an accepted sample
    do_start();
    drive(tab[0], 1'b1);
    step();
    bus.smp_valid = 1'b0;
    rst = 1'b1;
    #1;
    all_zero("rst_mid");
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst_no_strobe[%0d]", k), chk_valid, 0);
    end
    all_zero("rst_after");

    // samples in IDLE are ignored
    for (int k = 0; k < 4; k++) begin
      drive(tab[k], (k < 3) ? 1'b1 : 1'b0);
      step();
      chk($sformatf("idle_no_strobe[%0d]", k), chk_valid, 0);
    end
    step();
    all_zero("idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_8_bit_checker.md
ALU_8_BIT_CHECKER -- requirements
Module: alu_8_bit_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the pass, fail and skip counters.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that clears results and begins a check run.
REQ-005 SHALL have port smp_valid, input, 1: the current A/B/ALU_Sel/ALU_Out/CarryOut form one observed ALU transaction.
REQ-006 SHALL have ports A and B, input, 8 each: ALU operands as driven to the ALU.
REQ-007 SHALL have port ALU_Sel, input, 4: ALU opcode as driven.
REQ-008 SHALL have port ALU_Out, input, 8: ALU result under check.
REQ-009 SHALL have port CarryOut, input, 1: ALU carry flag under check.
REQ-010 SHALL have port chk_valid, output, 1: one-cycle strobe; a compare result is present.
REQ-011 SHALL have port chk_pass, output, 1: result of that compare; valid only with chk_valid.
REQ-012 SHALL have ports pass_cnt, fail_cnt and skip_cnt, output, CNT_W each: saturating counts.
REQ-013 SHALL have port first_fail_sel, output, 4: opcode of the first failing sample in the run.
REQ-014 SHALL have port err_sticky, output, 1: at least one failure seen in the run.
REQ-015 SHALL have port op_seen, output, 16: bit k set once opcode k has been checked (pass, fail or skip).
REQ-016 SHALL have port done, output, 1: high in state DONE.

Function
REQ-017 SHALL use the following expected-result map (8-bit, truncated):
- 0 A+B; 1 A-B; 2 A*B low byte; 3 A/B.
- 4 A<<1; 5 A>>1; 6 rotate A left 1; 7 rotate A right 1.
- 8 A&B; 9 A|B; A A^B; B ~(A|B); C ~(A&B); D ~(A^B).
- E: 1 if A>B else 0; F: 1 if A==B else 0.
REQ-018 SHALL compute expected CarryOut as bit 8 of {0,A}+{0,B} for every opcode.
REQ-019 SHALL treat opcode 3 with B==0 as a skip: increment skip_cnt, chk_valid=1, chk_pass=1, no pass/fail count.
REQ-020 SHALL use a 2-stage pipeline:
- stage 1 registers the accepted sample;
- stage 2 computes the expected values, compares ALU_Out and CarryOut, and updates the counters.
REQ-021 SHALL assert chk_valid exactly 2 cycles after an accepted smp_valid; back-to-back samples give back-to-back strobes.
REQ-022 SHALL implement the FSM IDLE -> RUN -> DONE:
- IDLE -> RUN on start.
- RUN -> DONE on the cycle after op_seen reaches 16'hFFFF, with the pipeline empty.
- DONE -> RUN on start.
REQ-023 SHALL accept smp_valid only in RUN; samples in IDLE or DONE are ignored and have no effect.
REQ-024 SHALL, on start in any state, in that cycle:
- flush both pipeline stages;
- clear the counters, op_seen, err_sticky and first_fail_sel;
- ignore any smp_valid in the same cycle.
REQ-025 SHALL saturate each counter at 2^CNT_W-1 with no wrap.
REQ-026 SHALL set err_sticky on the first fail and capture first_fail_sel; later fails SHALL NOT overwrite it.
REQ-027 SHALL keep draining in-flight samples after op_seen is full, and still count them, before entering DONE.

Reset
REQ-028 SHALL, while rst is high, force:
- state IDLE and both pipeline stages empty;
- chk_valid=0, chk_pass=0;
- all counters 0, first_fail_sel=0, err_sticky=0, op_seen=0, done=0.
REQ-029 SHALL, on rst asserted mid-run, discard in-flight samples; no chk_valid in the following cycles.

Verification
REQ-030 Sweep: start, then A=AA, B=55, sel 0..F, one per cycle, using a correct ALU model -> 16 strobes with chk_pass=1, pass_cnt=16, fail_cnt=0, done high 3 cycles after the last sample.
REQ-031 Spot values: A=AA, B=55:
- sel0 -> FF, carry 0.
- sel2 -> 72.
- sel6 -> 55.
- sel7 -> 55.
- sel E -> 01.
- sel F -> 00.
All SHALL pass.
REQ-032 Fault: sel 8 with ALU_Out=FF instead of 00 -> chk_pass=0, fail_cnt=1, err_sticky=1, first_fail_sel=8; a later fail on sel 9 leaves first_fail_sel=8.
REQ-033 Carry: A=FF, B=01, sel 8, CarryOut=0 -> fail (expected carry 1).
REQ-034 Div-by-zero: A=10, B=00, sel 3 -> skip_cnt=1, op_seen[3]=1, pass/fail unchanged.
REQ-035 Boundaries:
- CNT_W=2, 5 passes -> pass_cnt=3.
- rst pulse one cycle after a smp_valid -> no chk_valid, all outputs 0.
- smp_valid while in IDLE -> ignored.
